fa_using_ha: RTL and testbench

Registered ripple-carry adder whose every bit cell is a full adder built structurally from two half adders plus an OR gate. It adds two WIDTH-bit operands and a carry-in, and registers the sum and carry-out on the clock edge when the input is marked valid. With WIDTH=1 it is the single-bit full adder used as the arithmetic leaf cell in datapath blocks. Wider instances serve as a small pipelined adder stage.

---
 rtl/fa_using_ha.sv | 89 ++++++++
 tb/tb_fa_using_ha.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fa_using_ha.sv
// rtl/fa_using_ha.sv - registered ripple-carry adder built from half-adder pairs
//
// half_adder  : s = x ^ y, c = x & y
//   x, y      in   operand bits
//   s, c      out  sum and carry
//
// fa_using_ha : WIDTH-bit registered adder, {carry_out, sum_out} = a_in + b_in + c_in
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   capture a_in/b_in/c_in result this cycle
//   a_in      in   [WIDTH-1:0] operand A, unsigned
//   b_in      in   [WIDTH-1:0] operand B, unsigned
//   c_in      in   carry into bit 0
//   sum_out   out  [WIDTH-1:0] registered sum
//   carry_out out  registered carry out of the top bit
//   out_valid out  one-cycle pulse per captured result

module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = x ^ y;
    assign c = x & y;

endmodule

module fa_using_ha #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output logic             out_valid
);

    // k[i] is the carry into bit i; k[WIDTH] is the final carry.
    logic [WIDTH:0]   k;
    logic [WIDTH-1:0] sum_c;

    assign k[0] = c_in;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic p;   // propagate: a ^ b
        logic g;   // generate: a & b
        logic t;   // carry produced by adding the incoming carry to p

        half_adder u_ha1 (
            .x (a_in[gi]),
            .y (b_in[gi]),
            .s (p),
            .c (g)
        );

        half_adder u_ha2 (
            .x (p),
            .y (k[gi]),
            .s (sum_c[gi]),
            .c (t)
        );

        // g and t can never both be 1, so OR is an exact carry merge.
        assign k[gi+1] = g | t;
    end

    // Result registers only load when in_valid is set, so whatever sits on
    // the operand inputs during idle cycles cannot reach the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_out   <= '0;
            carry_out <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum_out   <= sum_c;
                carry_out <= k[WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_fa_using_ha.sv
// tb/tb_fa_using_ha.sv - scoreboard bench for fa_using_ha at WIDTH 1, 4 and 8

`timescale 1ns/1ps

module tb_fa_using_ha;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    logic       v1, a1, b1, c1, s1, co1, ov1;
    logic       v4, c4, co4, ov4;
    logic [3:0] a4, b4, s4;
    logic       v8, c8, co8, ov8;
    logic [7:0] a8, b8, s8;

    fa_using_ha #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .a_in(a1), .b_in(b1), .c_in(c1),
        .sum_out(s1), .carry_out(co1), .out_valid(ov1)
    );

    fa_using_ha #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .a_in(a4), .b_in(b4), .c_in(c4),
        .sum_out(s4), .carry_out(co4), .out_valid(ov4)
    );

    fa_using_ha #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .a_in(a8), .b_in(b8), .c_in(c8),
        .sum_out(s8), .carry_out(co8), .out_valid(ov8)
    );

    int checks   = 0;
    int failures = 0;

    // Expected {carry, sum} per DUT, plus the last result each should be holding.
    logic [1:0] q1[$];
    logic [4:0] q4[$];
    logic [8:0] q8[$];
    logic [1:0] last1 = '0;
    logic [4:0] last4 = '0;
    logic [8:0] last8 = '0;

    int ov8_cnt   = 0;
    int run8      = 0;
    int last_run8 = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitors: sample on the falling edge, away from the capture edge.
    always @(negedge clk) begin
        logic [1:0] e;
        if (ov1) begin
            if (q1.size() == 0) chk("w1_spurious_valid", 64'(q1.size()), 64'd1);
            else begin
                e = q1.pop_front();
                chk("w1_result", {co1, s1}, e);
                last1 = e;
            end
        end else begin
            chk("w1_hold", {co1, s1}, last1);
        end
    end

    always @(negedge clk) begin
        logic [4:0] e;
        if (ov4) begin
            if (q4.size() == 0) chk("w4_spurious_valid", 64'(q4.size()), 64'd1);
            else begin
                e = q4.pop_front();
                chk("w4_result", {co4, s4}, e);
                last4 = e;
            end
        end else begin
            chk("w4_hold", {co4, s4}, last4);
        end
    end

    always @(negedge clk) begin
        logic [8:0] e;
        if (ov8) begin
            ov8_cnt++;
            run8++;
            if (q8.size() == 0) chk("w8_spurious_valid", 64'(q8.size()), 64'd1);
            else begin
                e = q8.pop_front();
                chk("w8_result", {co8, s8}, e);
                last8 = e;
            end
        end else begin
            if (run8 != 0) last_run8 = run8;
            run8 = 0;
            chk("w8_hold", {co8, s8}, last8);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv1(input logic v, input logic a, input logic b, input logic c);
        v1 = v; a1 = a; b1 = b; c1 = c;
        if (v) q1.push_back(2'(int'(a) + int'(b) + int'(c)));
    endtask

    task automatic drv4(input logic v, input logic [3:0] a, input logic [3:0] b, input logic c);
        v4 = v; a4 = a; b4 = b; c4 = c;
        if (v) q4.push_back(5'(int'(a) + int'(b) + int'(c)));
    endtask

    task automatic drv8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c);
        v8 = v; a8 = a; b8 = b; c8 = c;
        if (v) q8.push_back(9'(int'(a) + int'(b) + int'(c)));
    endtask

    // Reset discards everything in flight and returns every output to zero.
    task automatic assert_reset();
        rst_n = 1'b0;
        q1.delete(); q4.delete(); q8.delete();
        last1 = '0; last4 = '0; last8 = '0;
    endtask

    initial begin
        logic [2:0] vec;
        v1 = 0; a1 = 0; b1 = 0; c1 = 0;
        v4 = 0; a4 = 0; b4 = 0; c4 = 0;
        v8 = 0; a8 = 0; b8 = 0; c8 = 0;
        assert_reset();

        // In_valid is ignored while reset is held.
        v8 = 1; a8 = 8'hFF; b8 = 8'hFF; c8 = 1;
        repeat (3) cyc();
        chk("reset_w1", {ov1, co1, s1}, 0);
        chk("reset_w4", {ov4, co4, s4}, 0);
        chk("reset_w8", {ov8, co8, s8}, 0);
        v8 = 0;
        rst_n = 1'b1;
        cyc();

        // WIDTH=1 exhaustive truth table, one vector per cycle.
        for (int i = 0; i < 8; i++) begin
            vec = 3'(i);
            drv1(1'b1, vec[2], vec[1], vec[0]);
            cyc();
        end
        drv1(1'b0, 1'b1, 1'b1, 1'b1);
        cyc();

        // WIDTH=4 ripple through all bits, wrap at maximum, then hold.
        drv4(1'b1, 4'hF, 4'h0, 1'b1);
        cyc();
        drv4(1'b1, 4'hF, 4'hF, 1'b1);
        cyc();
        drv4(1'b1, 4'h5, 4'h3, 1'b0);
        cyc();
        for (int i = 0; i < 3; i++) begin
            drv4(1'b0, 4'hA, 4'($urandom), 1'($urandom));
            cyc();
        end
        chk("w4_hold_sum", s4, 4'h8);
        chk("w4_hold_carry", co4, 1'b0);
        chk("w4_hold_valid", ov4, 1'b0);

        // Async reset with a result on the outputs and another in flight.
        drv8(1'b1, 8'h11, 8'h22, 1'b1);
        cyc();
        drv8(1'b1, 8'h33, 8'h44, 1'b0);
        chk("pre_reset_valid", ov8, 1'b1);
        #1;
        assert_reset();
        #1;
        chk("async_reset_w8", {ov8, co8, s8}, 0);
        chk("async_reset_w4", {ov4, co4, s4}, 0);
        chk("async_reset_w1", {ov1, co1, s1}, 0);
        cyc();
        cyc();
        v8 = 1'b0;
        rst_n = 1'b1;
        cyc();
        chk("post_release_valid", ov8, 1'b0);
        drv8(1'b1, 8'h02, 8'h02, 1'b0);
        cyc();
        chk("post_release_sum", {ov8, co8, s8}, {1'b1, 1'b0, 8'h04});
        drv8(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
        cyc();

        // Back-to-back: four consecutive valid vectors.
        begin
            int base;
            base = ov8_cnt;
            for (int i = 0; i < 4; i++) begin
                drv8(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
                cyc();
            end
            drv8(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
            repeat (3) cyc();
            chk("b2b_count", 64'(ov8_cnt - base), 64'd4);
            chk("b2b_run", 64'(last_run8), 64'd4);
        end

        // Randomized WIDTH=8 with random in_valid.
        for (int i = 0; i < 1000; i++) begin
            drv8(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
            cyc();
        end
        drv8(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
        repeat (3) cyc();

        chk("w1_drained", 64'(q1.size()), 64'd0);
        chk("w4_drained", 64'(q4.size()), 64'd0);
        chk("w8_drained", 64'(q8.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
